// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one memory port between two requesters: the fetch-side LSU, which
// only reads, and the data-side LSU, which reads and writes. Every port uses
// a 4-phase req/ack handshake. Only one transaction is in flight at a time.
// When both sides ask in the same cycle, the grant alternates (round-robin).
//
// Parameters
//   ADDR_W       address width
//   DATA_W       read/write data width
//
// Ports
//   clk_i, rst_ni                     clock, asynchronous active-low reset
//   if_req_i / if_addr_i              fetch request and address
//   if_ack_o / if_rdata_o / if_err_o  fetch ack, fetched word, bus error
//   ls_req_i / ls_addr_i / ls_we_i / ls_wdata_i
//                                     data request, address, write enable, data
//   ls_ack_o / ls_rdata_o / ls_err_o  data ack, load data, bus error
//   mem_req_o / mem_addr_o / mem_we_o / mem_wdata_o
//                                     request and payload to the memory
//   mem_ack_i / mem_rdata_i / mem_err_i
//                                     memory ack, read data, error
//
// Every output comes straight from a flop.
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_err_o,

    input  logic              ls_req_i,
    input  logic [ADDR_W-1:0] ls_addr_i,
    input  logic              ls_we_i,
    input  logic [DATA_W-1:0] ls_wdata_i,
    output logic              ls_ack_o,
    output logic [DATA_W-1:0] ls_rdata_o,
    output logic              ls_err_o,

    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_err_i
);

    // Transaction sequencing states
    localparam logic [1:0] ST_IDLE = 2'd0;  // waiting for a request
    localparam logic [1:0] ST_MREQ = 2'd1;  // mem_req_o high, waiting for mem_ack_i
    localparam logic [1:0] ST_MRTZ = 2'd2;  // waiting for mem_ack_i to drop
    localparam logic [1:0] ST_ACK  = 2'd3;  // requester ack high, waiting for its req to drop

    // Grant encoding, shared by grant_q and last_grant_q
    localparam logic GRANT_IF = 1'b0;
    localparam logic GRANT_LS = 1'b1;

    logic [1:0]        state_q,      state_d;
    logic              grant_q,      grant_d;
    logic              last_grant_q, last_grant_d;

    logic              mem_req_q,    mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic              mem_we_q,     mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;

    logic              if_ack_q,     if_ack_d;
    logic [DATA_W-1:0] if_rdata_q,   if_rdata_d;
    logic              if_err_q,     if_err_d;

    logic              ls_ack_q,     ls_ack_d;
    logic [DATA_W-1:0] ls_rdata_q,   ls_rdata_d;
    logic              ls_err_q,     ls_err_d;

    logic              pick_ls;
    logic              granted_req;

    // On a tie the side that did not win last time gets the port.
    // A lone requester always wins.
    assign pick_ls = ls_req_i && (!if_req_i || (last_grant_q == GRANT_IF));

    // The ACK state waits on the req line of whichever side holds the grant.
    assign granted_req = (grant_q == GRANT_LS) ? ls_req_i : if_req_i;

    // Next-state logic. The memory payload is captured once at grant time
    // and is not touched again until the next grant. Read data and error
    // flags keep their last value until that side completes again.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        mem_we_d     = mem_we_q;
        mem_wdata_d  = mem_wdata_q;
        if_ack_d     = if_ack_q;
        if_rdata_d   = if_rdata_q;
        if_err_d     = if_err_q;
        ls_ack_d     = ls_ack_q;
        ls_rdata_d   = ls_rdata_q;
        ls_err_d     = ls_err_q;

        case (state_q)
            ST_IDLE: begin
                if (if_req_i || ls_req_i) begin
                    state_d   = ST_MREQ;
                    mem_req_d = 1'b1;
                    if (pick_ls) begin
                        grant_d     = GRANT_LS;
                        mem_addr_d  = ls_addr_i;
                        mem_we_d    = ls_we_i;
                        mem_wdata_d = ls_wdata_i;
                    end else begin
                        // Fetches never write, so the write data is driven to zero.
                        grant_d     = GRANT_IF;
                        mem_addr_d  = if_addr_i;
                        mem_we_d    = 1'b0;
                        mem_wdata_d = '0;
                    end
                end
            end

            ST_MREQ: begin
                if (mem_ack_i) begin
                    state_d   = ST_MRTZ;
                    mem_req_d = 1'b0;
                    // Write responses pass mem_rdata_i through unchanged as well.
                    if (grant_q == GRANT_LS) begin
                        ls_rdata_d = mem_rdata_i;
                        ls_err_d   = mem_err_i;
                    end else begin
                        if_rdata_d = mem_rdata_i;
                        if_err_d   = mem_err_i;
                    end
                end
            end

            ST_MRTZ: begin
                if (!mem_ack_i) begin
                    state_d = ST_ACK;
                    if (grant_q == GRANT_LS) begin
                        ls_ack_d = 1'b1;
                    end else begin
                        if_ack_d = 1'b1;
                    end
                end
            end

            ST_ACK: begin
                // A requester that dropped req too early leaves here at once.
                if (!granted_req) begin
                    state_d      = ST_IDLE;
                    if_ack_d     = 1'b0;
                    ls_ack_d     = 1'b0;
                    last_grant_d = grant_q;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers. Reset abandons any transaction in flight.
    // last_grant starts at LS so that fetch wins the first tie.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            grant_q      <= GRANT_IF;
            last_grant_q <= GRANT_LS;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            if_ack_q     <= 1'b0;
            if_rdata_q   <= '0;
            if_err_q     <= 1'b0;
            ls_ack_q     <= 1'b0;
            ls_rdata_q   <= '0;
            ls_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            if_ack_q     <= if_ack_d;
            if_rdata_q   <= if_rdata_d;
            if_err_q     <= if_err_d;
            ls_ack_q     <= ls_ack_d;
            ls_rdata_q   <= ls_rdata_d;
            ls_err_q     <= ls_err_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_we_o    = mem_we_q;
    assign mem_wdata_o = mem_wdata_q;
    assign if_ack_o    = if_ack_q;
    assign if_rdata_o  = if_rdata_q;
    assign if_err_o    = if_err_q;
    assign ls_ack_o    = ls_ack_q;
    assign ls_rdata_o  = ls_rdata_q;
    assign ls_err_o    = ls_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed test of mem_port_arbiter. A small memory responder answers every
// memory request after a programmable number of cycles. The main initial
// block steps through the directed scenarios below, each with expected
// values worked out by hand:
//   - reset with both requests already high
//   - alternating grants under continuous contention
//   - lone loads, checked for latency
//   - a slow memory that returns an error
//   - reset asserted in the middle of a transaction
//   - a data request that arrives while a fetch is in flight
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;

    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_ack_o;
    logic [31:0] if_rdata_o;
    logic        if_err_o;

    logic        ls_req_i;
    logic [31:0] ls_addr_i;
    logic        ls_we_i;
    logic [31:0] ls_wdata_i;
    logic        ls_ack_o;
    logic [31:0] ls_rdata_o;
    logic        ls_err_o;

    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i   = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_err_i   = 1'b0;

    int          assertCount = 0;
    int          failCount   = 0;

    // Memory responder settings, changed by the directed steps
    int          memDelay    = 0;
    logic [31:0] memRdataVal = '0;
    logic        memErrVal   = 1'b0;
    int          memCnt      = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_ack_o    (if_ack_o),
        .if_rdata_o  (if_rdata_o),
        .if_err_o    (if_err_o),
        .ls_req_i    (ls_req_i),
        .ls_addr_i   (ls_addr_i),
        .ls_we_i     (ls_we_i),
        .ls_wdata_i  (ls_wdata_i),
        .ls_ack_o    (ls_ack_o),
        .ls_rdata_o  (ls_rdata_o),
        .ls_err_o    (ls_err_o),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_we_o    (mem_we_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .mem_err_i   (mem_err_i)
    );

    always #5 clk_i = ~clk_i;

    // Memory responder. On the falling edge it raises ack once the request
    // has been high for memDelay falling edges, and it drops ack once the
    // request is gone. With memDelay = 0, ack is seen on the first rising
    // edge after mem_req_o goes high.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            mem_ack_i = 1'b0;
            memCnt    = 0;
        end else if (mem_req_o && !mem_ack_i) begin
            if (memCnt >= memDelay) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = memRdataVal;
                mem_err_i   = memErrVal;
                memCnt      = 0;
            end else begin
                memCnt = memCnt + 1;
            end
        end else if (!mem_req_o && mem_ack_i) begin
            mem_ack_i = 1'b0;
        end
    end

    // Safety net so that a stuck design cannot hang the run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: counts it, and on a miss counts the failure and reports it
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drives every requester input at once
    task automatic applyStimulus(input logic ifReq, input logic [31:0] ifAddr,
                                 input logic lsReq, input logic [31:0] lsAddr,
                                 input logic lsWe, input logic [31:0] lsWdata);
        if_req_i   = ifReq;
        if_addr_i  = ifAddr;
        ls_req_i   = lsReq;
        ls_addr_i  = lsAddr;
        ls_we_i    = lsWe;
        ls_wdata_i = lsWdata;
    endtask

    // Every output must read as zero
    task automatic checkAllZero(input string tag);
        checkOutput({tag, " if_ack_o"},    if_ack_o,    32'h0);
        checkOutput({tag, " if_rdata_o"},  if_rdata_o,  32'h0);
        checkOutput({tag, " if_err_o"},    if_err_o,    32'h0);
        checkOutput({tag, " ls_ack_o"},    ls_ack_o,    32'h0);
        checkOutput({tag, " ls_rdata_o"},  ls_rdata_o,  32'h0);
        checkOutput({tag, " ls_err_o"},    ls_err_o,    32'h0);
        checkOutput({tag, " mem_req_o"},   mem_req_o,   32'h0);
        checkOutput({tag, " mem_addr_o"},  mem_addr_o,  32'h0);
        checkOutput({tag, " mem_we_o"},    mem_we_o,    32'h0);
        checkOutput({tag, " mem_wdata_o"}, mem_wdata_o, 32'h0);
    endtask

    // Waits, within a cycle budget, for the memory request to appear
    task automatic waitMemReq(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (mem_req_o) break;
            @(negedge clk_i);
        end
        checkOutput({tag, " mem_req_o"}, mem_req_o, 32'h1);
    endtask

    // Waits, within a cycle budget, for the ack of one side
    task automatic waitAck(input string tag, input bit isLs);
        for (int i = 0; i < 40; i++) begin
            if (isLs ? ls_ack_o : if_ack_o) break;
            @(negedge clk_i);
        end
        checkOutput({tag, " ack"}, isLs ? ls_ack_o : if_ack_o, 32'h1);
    endtask

    // Runs one transaction for one side. The side's request must already be
    // high (or about to be granted). The task checks the payload at grant
    // time, the response, and the ack release. With rearm set, the request
    // is raised again right after the ack drops.
    task automatic runTransaction(input string tag, input bit isLs,
                                  input logic [31:0] expAddr, input logic expWe,
                                  input logic [31:0] expWdata, input logic [31:0] rdata,
                                  input logic err, input bit rearm);
        memRdataVal = rdata;
        memErrVal   = err;
        waitMemReq(tag);
        checkOutput({tag, " mem_addr_o"},  mem_addr_o,  expAddr);
        checkOutput({tag, " mem_we_o"},    mem_we_o,    {31'h0, expWe});
        checkOutput({tag, " mem_wdata_o"}, mem_wdata_o, expWdata);
        waitAck(tag, isLs);
        checkOutput({tag, " other ack"}, isLs ? if_ack_o : ls_ack_o, 32'h0);
        checkOutput({tag, " rdata"}, isLs ? ls_rdata_o : if_rdata_o, rdata);
        checkOutput({tag, " err"},   isLs ? ls_err_o   : if_err_o,   {31'h0, err});
        checkOutput({tag, " addr held"}, mem_addr_o, expAddr);
        if (isLs) ls_req_i = 1'b0;
        else      if_req_i = 1'b0;
        @(negedge clk_i);
        checkOutput({tag, " ack released"}, isLs ? ls_ack_o : if_ack_o, 32'h0);
        if (rearm) begin
            if (isLs) ls_req_i = 1'b1;
            else      if_req_i = 1'b1;
        end
    endtask

    initial begin
        // ---- 1: reset with both requests high; fetch wins the first tie ----
        $display("[TB] step 1: reset with both requests high");
        rst_ni = 1'b0;
        applyStimulus(1'b1, 32'h0000_0100, 1'b1, 32'h0000_0200, 1'b1, 32'hDEAD_BEEF);
        repeat (3) @(negedge clk_i);
        checkAllZero("reset");
        rst_ni = 1'b1;

        // ---- 2: continuous contention alternates F,L,F,L,F,L ----
        $display("[TB] step 2: continuous contention");
        runTransaction("t1 F", 1'b0, 32'h0000_0100, 1'b0, 32'h0, 32'h0000_0013, 1'b0, 1'b1);
        runTransaction("t2 L", 1'b1, 32'h0000_0200, 1'b1, 32'hDEAD_BEEF, 32'hA5A5_0001, 1'b0, 1'b1);
        runTransaction("t3 F", 1'b0, 32'h0000_0100, 1'b0, 32'h0, 32'h0000_0093, 1'b0, 1'b1);
        runTransaction("t4 L", 1'b1, 32'h0000_0200, 1'b1, 32'hDEAD_BEEF, 32'hA5A5_0002, 1'b0, 1'b1);
        runTransaction("t5 F", 1'b0, 32'h0000_0100, 1'b0, 32'h0, 32'h0000_0113, 1'b0, 1'b0);
        runTransaction("t6 L", 1'b1, 32'h0000_0200, 1'b1, 32'hDEAD_BEEF, 32'hA5A5_0003, 1'b0, 1'b0);
        checkOutput("if_rdata holds", if_rdata_o, 32'h0000_0113);

        // ---- 3: lone loads; ack shows up on the third edge after req rises ----
        $display("[TB] step 3: lone loads");
        for (int i = 0; i < 3; i++) begin
            memRdataVal = 32'h0000_1000 + i;
            applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_0300 + 4 * i, 1'b0, 32'h0);
            @(negedge clk_i);
            checkOutput("load grant mem_req_o", mem_req_o, 32'h1);
            checkOutput("load grant mem_addr_o", mem_addr_o, 32'h0000_0300 + 4 * i);
            checkOutput("load early ls_ack_o", ls_ack_o, 32'h0);
            @(negedge clk_i);
            checkOutput("load mrtz ls_ack_o", ls_ack_o, 32'h0);
            @(negedge clk_i);
            checkOutput("load ls_ack_o", ls_ack_o, 32'h1);
            checkOutput("load if_ack_o", if_ack_o, 32'h0);
            checkOutput("load ls_rdata_o", ls_rdata_o, 32'h0000_1000 + i);
            ls_req_i = 1'b0;
            @(negedge clk_i);
            checkOutput("load ack released", ls_ack_o, 32'h0);
        end

        // ---- 4: slow memory returning an error on a fetch ----
        $display("[TB] step 4: slow memory with error");
        memDelay    = 4;
        memErrVal   = 1'b1;
        memRdataVal = 32'hBAD0_0BAD;
        applyStimulus(1'b1, 32'h0000_0400, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            checkOutput("slow mem_req_o held", mem_req_o, 32'h1);
            checkOutput("slow if_ack_o low", if_ack_o, 32'h0);
        end
        @(negedge clk_i);
        checkOutput("slow mem_req_o dropped", mem_req_o, 32'h0);
        checkOutput("slow ack waits for mem_ack low", if_ack_o, 32'h0);
        @(negedge clk_i);
        checkOutput("slow if_ack_o", if_ack_o, 32'h1);
        checkOutput("slow if_err_o", if_err_o, 32'h1);
        checkOutput("slow if_rdata_o", if_rdata_o, 32'hBAD0_0BAD);
        if_req_i = 1'b0;
        @(negedge clk_i);
        checkOutput("slow ack released", if_ack_o, 32'h0);
        memDelay  = 0;
        memErrVal = 1'b0;

        // ---- 5: reset while in ACK; no stale ack afterwards ----
        $display("[TB] step 5: reset during ack");
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_0500, 1'b0, 32'h0);
        memRdataVal = 32'h0000_5555;
        waitAck("pre-reset load", 1'b1);
        #2;
        rst_ni = 1'b0;
        #1;
        checkAllZero("async reset");
        @(negedge clk_i);
        checkAllZero("held reset");
        rst_ni = 1'b1;
        checkOutput("release ls_ack_o", ls_ack_o, 32'h0);
        runTransaction("post-reset L", 1'b1, 32'h0000_0500, 1'b0, 32'h0, 32'h0000_6666, 1'b0, 1'b0);

        // ---- 6: data request arrives while a fetch is in flight ----
        $display("[TB] step 6: data request during fetch");
        memDelay    = 2;
        memRdataVal = 32'h0600_0600;
        applyStimulus(1'b1, 32'h0000_0600, 1'b0, 32'h0, 1'b0, 32'h0);
        waitMemReq("late ls fetch");
        applyStimulus(1'b1, 32'h0000_0600, 1'b1, 32'h0000_0700, 1'b1, 32'h1234_5678);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            checkOutput("late ls mem_addr_o stable", mem_addr_o, 32'h0000_0600);
            checkOutput("late ls mem_we_o stable", mem_we_o, 32'h0);
            checkOutput("late ls ls_ack_o waits", ls_ack_o, 32'h0);
            if (if_ack_o) break;
        end
        checkOutput("late ls fetch ack", if_ack_o, 32'h1);
        checkOutput("late ls fetch rdata", if_rdata_o, 32'h0600_0600);
        if_req_i    = 1'b0;
        memRdataVal = 32'h0000_7777;
        @(negedge clk_i);
        checkOutput("late ls idle mem_req_o", mem_req_o, 32'h0);
        checkOutput("late ls fetch ack released", if_ack_o, 32'h0);
        @(negedge clk_i);
        checkOutput("late ls grant mem_req_o", mem_req_o, 32'h1);
        checkOutput("late ls grant mem_addr_o", mem_addr_o, 32'h0000_0700);
        checkOutput("late ls grant mem_we_o", mem_we_o, 32'h1);
        checkOutput("late ls grant mem_wdata_o", mem_wdata_o, 32'h1234_5678);
        waitAck("late ls write", 1'b1);
        checkOutput("late ls write rdata", ls_rdata_o, 32'h0000_7777);
        ls_req_i = 1'b0;
        @(negedge clk_i);
        checkOutput("late ls write ack released", ls_ack_o, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
